// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps
// UART transmit path: byte FIFO feeding an 8N1/8E1 serialiser.
// Bit timing comes entirely from the external clken baud pulse.
module uart_transmitter #(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       tx,
  output logic       full,
  output logic       busy,
  output logic       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] ONE      = (PW+1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          empty;
  logic          push;
  logic          pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign busy  = (state != IDLE) || !empty;
  assign push  = wr_en && !full && !rst;
  // Count is sampled before the edge, so a fresh push is never popped at once
  assign pop   = clken && !rst && !empty &&
                 ((state == IDLE) || (state == STOP));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clken) begin
      unique case (state)
        IDLE: begin
          tx <= empty;
          if (!empty) begin
            shreg <= mem[rd_ptr];
            state <= START;
          end
        end
        START: begin
          tx      <= shreg[0];
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          if (bit_cnt == 3'd7) begin
            if (PARITY_EN != 0) begin
              tx    <= ^shreg;
              state <= PARITY;
            end else begin
              tx    <= 1'b1;
              state <= STOP;
            end
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            tx      <= shreg[bit_cnt + 3'd1];
          end
        end
        PARITY: begin
          tx    <= 1'b1;
          state <= STOP;
        end
        STOP: begin
          // Chain straight into the next start bit when more data waits
          if (!empty) begin
            shreg <= mem[rd_ptr];
            tx    <= 1'b0;
            state <= START;
          end else begin
            tx    <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
// Directed bench for uart_transmitter: 8N1 and 8E1 instances in parallel.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clken;
  logic       wr_en;
  logic [7:0] din;
  logic       tx0, full0, busy0, ov0;
  logic       tx1, full1, busy1, ov1;

  int         per;
  logic       gen_en;
  logic       man;
  logic       man_en;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [63:0] f;
  int         w;
  logic       seen;
  logic [7:0] ob [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  assign clken = man ? man_en : gen_en;

  always #5 clk = ~clk;

  uart_transmitter #(.FIFO_DEPTH(4), .PARITY_EN(0)) u0 (
    .clk(clk), .rst(rst), .clken(clken), .wr_en(wr_en), .din(din),
    .tx(tx0), .full(full0), .busy(busy0), .overflow(ov0)
  );

  uart_transmitter #(.FIFO_DEPTH(4), .PARITY_EN(1)) u1 (
    .clk(clk), .rst(rst), .clken(clken), .wr_en(wr_en), .din(din),
    .tx(tx1), .full(full1), .busy(busy1), .overflow(ov1)
  );

  initial begin
    int cnt;
    gen_en = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (per == 0) begin
        gen_en = 1'b0;
        cnt = 0;
      end else if (cnt >= per - 1) begin
        gen_en = 1'b1;
        cnt = 0;
      end else begin
        gen_en = 1'b0;
        cnt++;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic txs(input int sel);
    return (sel != 0) ? tx1 : tx0;
  endfunction

  task automatic write(input logic [7:0] d);
    @(posedge clk);
    #1;
    wr_en = 1'b1;
    din = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse();
    @(posedge clk);
    #1;
    man_en = 1'b1;
    @(posedge clk);
    #1;
    man_en = 1'b0;
  endtask

  task automatic recv(input int sel, input int nbits, input int pclk,
                      output logic [63:0] fr, output int waited);
    fr = '0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (txs(sel) != 1'b0 && waited < 1000);
    chk("rx_fall", txs(sel), 0);
    if (txs(sel) != 1'b0) return;
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) repeat (pclk) @(negedge clk);
      fr[i] = txs(sel);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy0 || busy1) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("idle", busy0 | busy1, 0);
  endtask

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    din = '0;
    per = 0;
    man = 1'b0;
    man_en = 1'b0;

    @(posedge clk);
    #1;
    wr_en = 1'b1;
    din = 8'h5A;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_tx0", tx0, 1);
    chk("rst_tx1", tx1, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_full", full0, 0);
    chk("rst_ovf", ov0, 0);
    wr_en = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_wr_ignored", busy0, 0);

    per = 16;
    write(8'h55);
    recv(0, 10, 16, f, w);
    chk("b55_frame", f, 64'h2AA);
    chk("b55_busy_stop", busy0, 1);
    repeat (16) @(negedge clk);
    chk("b55_busy_end", busy0, 0);
    chk("b55_tx_idle", tx0, 1);
    wait_idle();

    per = 1;
    write(8'h3C);
    recv(0, 10, 1, f, w);
    chk("lat_wait", w, 2);
    chk("lat_frame", f, 64'h278);
    wait_idle();

    per = 16;
    write(8'h07);
    recv(1, 11, 16, f, w);
    chk("par_07", f, 64'h60E);
    wait_idle();
    write(8'h03);
    recv(1, 11, 16, f, w);
    chk("par_03", f, 64'h406);
    wait_idle();

    @(posedge clk);
    #1;
    wr_en = 1'b1;
    din = 8'hA5;
    @(posedge clk);
    #1;
    din = 8'h3C;
    @(posedge clk);
    #1;
    din = 8'hFF;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    recv(0, 30, 16, f, w);
    chk("b2b_frames", f, {10'h3FE, 10'h278, 10'h34A});
    chk("b2b_busy_stop", busy0, 1);
    repeat (16) @(negedge clk);
    chk("b2b_busy_end", busy0, 0);
    wait_idle();

    per = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;
      din = ob[i];
      @(posedge clk);
      #1;
      chk("ovf_full", full0, (i >= 3) ? 1 : 0);
      chk("ovf_pulse", ov0, (i >= 4) ? 1 : 0);
    end
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    chk("ovf_clear", ov0, 0);
    per = 16;
    recv(0, 40, 16, f, w);
    chk("ovf_frames", f, {10'h288, 10'h266, 10'h244, 10'h222});
    repeat (16) @(negedge clk);
    chk("ovf_busy_end", busy0, 0);
    wait_idle();

    @(posedge clk);
    #1;
    wr_en = 1'b1;
    din = 8'h81;
    @(posedge clk);
    #1;
    din = 8'h01;
    @(posedge clk);
    #1;
    din = 8'h02;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    recv(0, 5, 16, f, w);
    chk("mid_pre", f, 64'h02);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_tx", tx0, 1);
    chk("mid_busy", busy0, 0);
    chk("mid_full", full0, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (!tx0 || busy0) seen = 1'b1;
    end
    chk("mid_quiet", seen, 0);

    per = 0;
    man = 1'b1;
    man_en = 1'b0;
    write(8'h99);
    pulse();
    write(8'hC1);
    write(8'hC2);
    write(8'hC3);
    write(8'hC4);
    chk("bnd_full", full0, 1);
    repeat (9) pulse();
    chk("bnd_stop_tx", tx0, 1);
    @(posedge clk);
    #1;
    man_en = 1'b1;
    wr_en = 1'b1;
    din = 8'hEE;
    @(posedge clk);
    #1;
    man_en = 1'b0;
    wr_en = 1'b0;
    chk("bnd_ovf", ov0, 1);
    chk("bnd_not_full", full0, 0);
    chk("bnd_start", tx0, 0);
    write(8'hDD);
    chk("bnd_refull", full0, 1);
    chk("bnd_no_ovf", ov0, 0);
    write(8'hCC);
    chk("bnd_ovf2", ov0, 1);
    man = 1'b0;
    per = 1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
